// File: rtl/cap_cmd_if.sv
// cap_cmd_if: framed command byte bus from the host command router.
// One byte per valid cycle; last marks the final byte of a frame.
interface cap_cmd_if;
    logic [7:0] data;
    logic       last;
    logic       valid;

    modport master (
        output data,
        output last,
        output valid
    );

    modport slave (
        input data,
        input last,
        input valid
    );
endinterface

// File: rtl/cap_cmd_decoder.sv
// cap_cmd_decoder: validate-then-commit parser for capture-config frames.
// Define CAP_CMD_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module cap_cmd_decoder #(
    parameter int SPEED_W = 24,
    parameter int CH_NUM  = 8,
    parameter int MAX_LEN = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    cap_cmd_if.slave           cmd_i,
    input  logic               i_system_run,
    input  logic [7:0]         i_def_chnnel,
    input  logic [SPEED_W-1:0] i_def_speed,
    input  logic               i_def_start,
    input  logic               i_def_trig,
    output logic [7:0]         o_cap_chnnel_num,
    output logic [SPEED_W-1:0] o_cap_speed,
    output logic               o_cap_enable,
    output logic               o_cap_trigger,
    output logic               o_cap_seek,
    output logic               o_cmd_ok,
    output logic               o_cmd_err,
    output logic [2:0]         o_err_code
);

    localparam logic [7:0] CH_MAX  = 8'(CH_NUM);
    localparam logic [7:0] MAX_L   = 8'(MAX_LEN);
    localparam logic [7:0] SPEED_B = 8'(SPEED_W / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAY,
        S_CK,
        S_DRAIN
    } state_e;

    function automatic logic [7:0] req_len(input logic [7:0] t);
        logic [7:0] r;
        r = 8'd0;
        case (t)
            8'd1, 8'd3, 8'd4: r = 8'd1;
            8'd2:             r = SPEED_B;
            default:          r = 8'd0;
        endcase
        return r;
    endfunction

    logic [7:0]         dat_q;
    logic               lst_q;
    logic               vld_q;
    logic [2:0]         run_q;
    logic               run_rise;

    state_e             state_q, state_d, nxt;
    logic [7:0]         type_q, type_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [SPEED_W-1:0] shd_q, shd_d;
    logic [2:0]         pend_q, pend_d;
`ifdef CAP_CMD_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
`endif

    logic [2:0]         bad;
    logic               done;
    logic               fin;
    logic [2:0]         fcode;

    logic [7:0]         chan_q;
    logic [SPEED_W-1:0] speed_q;
    logic               en_q;
    logic               trig_q;
    logic               seek_q;
    logic               ok_q;
    logic               err_q;
    logic [2:0]         code_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dat_q <= '0;
            lst_q <= 1'b0;
            vld_q <= 1'b0;
            run_q <= '0;
        end else begin
            dat_q <= cmd_i.data;
            lst_q <= cmd_i.last;
            vld_q <= cmd_i.valid;
            run_q <= {run_q[1:0], i_system_run};
        end
    end

    assign run_rise = run_q[1] & ~run_q[2];

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        shd_d   = shd_q;
        pend_d  = pend_q;
        nxt     = state_q;
        bad     = 3'd0;
        done    = 1'b0;
        fin     = 1'b0;
        fcode   = 3'd0;
`ifdef CAP_CMD_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (vld_q) begin
`ifdef CAP_CMD_CHECKSUM_EN
            sum_d = sum_q + dat_q;
`endif
            unique case (state_q)
                S_IDLE: begin
                    type_d = dat_q;
                    cnt_d  = '0;
                    shd_d  = '0;
`ifdef CAP_CMD_CHECKSUM_EN
                    sum_d  = dat_q;
`endif
                    nxt = S_LEN;
                    if (lst_q)
                        bad = 3'd2;
                    else if (dat_q == 8'd0 || dat_q > 8'd5)
                        bad = 3'd1;
                end
                S_LEN: begin
                    len_d = dat_q;
                    nxt   = S_PAY;
                    if (dat_q > MAX_L || dat_q != req_len(type_q))
                        bad = 3'd2;
                    else if (dat_q == 8'd0) begin
`ifdef CAP_CMD_CHECKSUM_EN
                        nxt = S_CK;
`else
                        done = 1'b1;
`endif
                    end
                end
                S_PAY: begin
                    cnt_d = cnt_q + 8'd1;
                    shd_d = (shd_q << 8) | SPEED_W'(dat_q);
                    if (cnt_d == len_q) begin
                        if (type_q == 8'd1 &&
                            (dat_q == 8'd0 || dat_q > CH_MAX))
                            bad = 3'd5;
`ifdef CAP_CMD_CHECKSUM_EN
                        nxt = S_CK;
`else
                        done = 1'b1;
`endif
                    end
                end
`ifdef CAP_CMD_CHECKSUM_EN
                S_CK: begin
                    done = 1'b1;
                    if (dat_q != sum_q)
                        bad = 3'd3;
                end
`endif
                default: ;
            endcase

            // First error seen is latched in pend_q; DRAIN only waits for last.
            if (state_q == S_DRAIN) begin
                if (lst_q) begin
                    fin     = 1'b1;
                    fcode   = pend_q;
                    state_d = S_IDLE;
                end
            end else if (bad != 3'd0) begin
                if (lst_q) begin
                    fin     = 1'b1;
                    fcode   = bad;
                    state_d = S_IDLE;
                end else begin
                    pend_d  = bad;
                    state_d = S_DRAIN;
                end
            end else if (done) begin
                if (lst_q) begin
                    fin     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    pend_d  = 3'd2;
                    state_d = S_DRAIN;
                end
            end else if (lst_q) begin
                fin     = 1'b1;
                fcode   = 3'd2;
                state_d = S_IDLE;
            end else begin
                state_d = nxt;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            type_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            shd_q   <= '0;
            pend_q  <= '0;
`ifdef CAP_CMD_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            shd_q   <= shd_d;
            pend_q  <= pend_d;
`ifdef CAP_CMD_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            chan_q  <= '0;
            speed_q <= '0;
            en_q    <= 1'b0;
            trig_q  <= 1'b0;
            seek_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            ok_q   <= 1'b0;
            err_q  <= 1'b0;
            seek_q <= 1'b0;
            if (run_rise) begin
                chan_q  <= i_def_chnnel;
                speed_q <= i_def_speed;
                en_q    <= i_def_start;
                trig_q  <= i_def_trig;
            end
            // A commit landing on the run edge loses to the defaults.
            if (fin) begin
                if (fcode != 3'd0) begin
                    err_q  <= 1'b1;
                    code_q <= fcode;
                end else if (run_rise) begin
                    err_q  <= 1'b1;
                    code_q <= 3'd4;
                end else begin
                    ok_q <= 1'b1;
                    unique case (type_q)
                        8'd1:    chan_q  <= shd_d[7:0];
                        8'd2:    speed_q <= shd_d;
                        8'd3:    en_q    <= shd_d[0];
                        8'd4:    trig_q  <= shd_d[0];
                        default: seek_q  <= 1'b1;
                    endcase
                end
            end
        end
    end

    assign o_cap_chnnel_num = chan_q;
    assign o_cap_speed      = speed_q;
    assign o_cap_enable     = en_q;
    assign o_cap_trigger    = trig_q;
    assign o_cap_seek       = seek_q;
    assign o_cmd_ok         = ok_q;
    assign o_cmd_err        = err_q;
    assign o_err_code       = code_q;

endmodule

// File: tb/tb_cap_cmd_decoder.sv
// tb_cap_cmd_decoder: frame-level reference model plus per-cycle compare.
// Directed frames pin the model; random frames exercise errors and gaps.
module tb_cap_cmd_decoder;

    localparam int SPEED_W = 24;
    localparam int CH_NUM  = 8;
    localparam int MAX_LEN = 8;
`ifdef CAP_CMD_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    typedef logic [7:0] byte_t;

    typedef struct packed {
        logic               fr;
        logic [2:0]         code;
        logic [7:0]         typ;
        logic [SPEED_W-1:0] val;
        logic               ld;
        logic [7:0]         dch;
        logic [SPEED_W-1:0] dsp;
        logic               den;
        logic               dtr;
    } ev_t;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_system_run;
    logic [7:0]         i_def_chnnel;
    logic [SPEED_W-1:0] i_def_speed;
    logic               i_def_start;
    logic               i_def_trig;
    logic [7:0]         o_cap_chnnel_num;
    logic [SPEED_W-1:0] o_cap_speed;
    logic               o_cap_enable;
    logic               o_cap_trigger;
    logic               o_cap_seek;
    logic               o_cmd_ok;
    logic               o_cmd_err;
    logic [2:0]         o_err_code;

    cap_cmd_if bus();

    cap_cmd_decoder #(
        .SPEED_W(SPEED_W),
        .CH_NUM (CH_NUM),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .cmd_i           (bus),
        .i_system_run    (i_system_run),
        .i_def_chnnel    (i_def_chnnel),
        .i_def_speed     (i_def_speed),
        .i_def_start     (i_def_start),
        .i_def_trig      (i_def_trig),
        .o_cap_chnnel_num(o_cap_chnnel_num),
        .o_cap_speed     (o_cap_speed),
        .o_cap_enable    (o_cap_enable),
        .o_cap_trigger   (o_cap_trigger),
        .o_cap_seek      (o_cap_seek),
        .o_cmd_ok        (o_cmd_ok),
        .o_cmd_err       (o_cmd_err),
        .o_err_code      (o_err_code)
    );

    initial forever #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    ev_t                ev[8];
    byte_t              fq[$];
    logic [7:0]         e_ch;
    logic [SPEED_W-1:0] e_sp;
    logic               e_en, e_tr;
    logic [2:0]         e_code;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        e_ch = '0; e_sp = '0; e_en = 1'b0; e_tr = 1'b0; e_code = '0;
        for (int i = 0; i < 8; i++) ev[i] = '0;
    endtask

    // Outcome of a whole frame from the command rules alone.
    function automatic void frame_eval(input byte_t q[$],
                                       output logic [2:0] code,
                                       output logic [SPEED_W-1:0] val);
        int n, len, req, exp_n;
        byte_t sum;
        n = q.size();
        code = 3'd0;
        val  = '0;
        if (n == 1) begin
            code = 3'd2;
        end else if (q[0] < 1 || q[0] > 5) begin
            code = 3'd1;
        end else begin
            len   = int'(q[1]);
            req   = (q[0] == 2) ? SPEED_W / 8 : (q[0] == 5) ? 0 : 1;
            exp_n = 2 + len + CK;
            if (len > MAX_LEN || len != req) code = 3'd2;
            else if (n < 2 + len) code = 3'd2;
            else if (q[0] == 1 && (q[2] == 0 || q[2] > CH_NUM)) code = 3'd5;
            else if (n < exp_n) code = 3'd2;
            else begin
                sum = 8'd0;
                for (int i = 0; i < 2 + len; i++) sum = sum + q[i];
                if (CK == 1 && q[2 + len] != sum) code = 3'd3;
                else if (n > exp_n) code = 3'd2;
            end
            if (code == 3'd0)
                for (int i = 0; i < len; i++)
                    val = (val << 8) | SPEED_W'(q[2 + i]);
        end
    endfunction

    always @(negedge i_clk) begin
        ev_t e;
        logic p_ok, p_err, p_sk;
        if (!i_rst) begin
            e = ev[cyc % 8];
            ev[cyc % 8] = '0;
            p_ok = 1'b0; p_err = 1'b0; p_sk = 1'b0;
            if (e.ld) begin
                e_ch = e.dch; e_sp = e.dsp; e_en = e.den; e_tr = e.dtr;
            end
            if (e.fr) begin
                if (e.code != 3'd0) begin
                    p_err = 1'b1; e_code = e.code;
                end else if (e.ld) begin
                    p_err = 1'b1; e_code = 3'd4;
                end else begin
                    p_ok = 1'b1;
                    case (e.typ)
                        8'd1: e_ch = e.val[7:0];
                        8'd2: e_sp = e.val;
                        8'd3: e_en = e.val[0];
                        8'd4: e_tr = e.val[0];
                        default: p_sk = 1'b1;
                    endcase
                end
            end
            chk("chan", 32'(o_cap_chnnel_num), 32'(e_ch));
            chk("speed", 32'(o_cap_speed), 32'(e_sp));
            chk("enable", 32'(o_cap_enable), 32'(e_en));
            chk("trigger", 32'(o_cap_trigger), 32'(e_tr));
            chk("seek", 32'(o_cap_seek), 32'(p_sk));
            chk("ok", 32'(o_cmd_ok), 32'(p_ok));
            chk("err", 32'(o_cmd_err), 32'(p_err));
            chk("code", 32'(o_err_code), 32'(e_code));
        end
    end

    task automatic add_ck(input bit corrupt);
`ifdef CAP_CMD_CHECKSUM_EN
        byte_t s;
        s = 8'd0;
        foreach (fq[i]) s = s + fq[i];
        if (corrupt) s = s ^ byte_t'($urandom_range(1, 255));
        fq.push_back(s);
`else
        if (corrupt) fq = fq;
`endif
    endtask

    task automatic send_frame(input byte_t q[$], input int gap_max,
                              input bit tail, input int run_at);
        logic [2:0] code;
        logic [SPEED_W-1:0] val;
        int s, g;
        for (int i = 0; i < q.size(); i++) begin
            g = (i > 0 && gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            repeat (g) begin
                @(posedge i_clk); #1;
                bus.valid = 1'b0;
                bus.data  = byte_t'($urandom);
                bus.last  = 1'($urandom);
            end
            @(posedge i_clk); #1;
            bus.valid = 1'b1;
            bus.data  = q[i];
            bus.last  = (i == q.size() - 1);
            if (i == run_at) begin
                i_system_run = 1'b1;
                s = (cyc + 3) % 8;
                ev[s].ld  = 1'b1;
                ev[s].dch = i_def_chnnel;
                ev[s].dsp = i_def_speed;
                ev[s].den = i_def_start;
                ev[s].dtr = i_def_trig;
            end
            if (i == q.size() - 1) begin
                frame_eval(q, code, val);
                s = (cyc + 2) % 8;
                ev[s].fr   = 1'b1;
                ev[s].code = code;
                ev[s].typ  = q[0];
                ev[s].val  = val;
            end
        end
        if (tail) begin
            @(posedge i_clk); #1;
            bus.valid = 1'b0;
            bus.last  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk); #1;
            bus.valid = 1'b0;
            bus.last  = 1'b0;
        end
    endtask

    // Call right after a tail-idled frame: pulse lands on the second negedge.
    task automatic lit_pulse(input logic xok, input logic xerr);
        @(negedge i_clk);
        chk("lit_ok_early", 32'(o_cmd_ok), 32'd0);
        @(negedge i_clk);
        chk("lit_ok", 32'(o_cmd_ok), 32'(xok));
        chk("lit_err", 32'(o_cmd_err), 32'(xerr));
    endtask

    task automatic rand_frame();
        int t, req, len, r;
        fq.delete();
        r = $urandom_range(0, 9);
        if (r == 0) t = $urandom_range(6, 255);
        else if (r == 1) t = 0;
        else t = $urandom_range(1, 5);
        req = (t == 2) ? SPEED_W / 8 : (t == 5) ? 0 : 1;
        len = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 12) : req;
        fq.push_back(byte_t'(t));
        fq.push_back(byte_t'(len));
        for (int i = 0; i < len; i++)
            if (t == 1 && $urandom_range(0, 1) == 1)
                fq.push_back(byte_t'($urandom_range(0, 10)));
            else
                fq.push_back(byte_t'($urandom));
        add_ck($urandom_range(0, 9) == 0);
        r = $urandom_range(0, 9);
        if (r == 0) begin
            r = $urandom_range(1, fq.size());
            while (fq.size() > r) void'(fq.pop_back());
        end else if (r == 1) begin
            fq.push_back(byte_t'($urandom));
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_system_run = 1'b0;
        i_def_chnnel = 8'd0;
        i_def_speed  = '0;
        i_def_start  = 1'b0;
        i_def_trig   = 1'b0;
        bus.valid = 1'b0;
        bus.last  = 1'b0;
        bus.data  = 8'd0;
        model_clear();
        repeat (3) @(posedge i_clk);
        #2;
        chk("rst_chan", 32'(o_cap_chnnel_num), 32'd0);
        chk("rst_speed", 32'(o_cap_speed), 32'd0);
        chk("rst_ok_err", 32'({o_cmd_ok, o_cmd_err, o_cap_seek}), 32'd0);
        chk("rst_code", 32'(o_err_code), 32'd0);
        i_rst = 1'b0;

        fq = {8'h02, 8'h03, 8'h01, 8'h86, 8'hA0};
        add_ck(1'b0);
        send_frame(fq, 0, 1'b1, -1);
        lit_pulse(1'b1, 1'b0);
        idle(2);
        chk("lit_speed", 32'(o_cap_speed), 32'h0186A0);

        fq = {8'h01, 8'h01, 8'h09};
        add_ck(1'b0);
        send_frame(fq, 0, 1'b1, -1);
        lit_pulse(1'b0, 1'b1);
        chk("lit_code5", 32'(o_err_code), 32'd5);
        chk("lit_chan_keep", 32'(o_cap_chnnel_num), 32'd0);
        fq = {8'h01, 8'h01, 8'h04};
        add_ck(1'b0);
        send_frame(fq, 0, 1'b1, -1);
        idle(2);
        chk("lit_chan4", 32'(o_cap_chnnel_num), 32'd4);

        fq = {8'h03, 8'h02, 8'h01, 8'h01};
        add_ck(1'b0);
        send_frame(fq, 0, 1'b1, -1);
        idle(2);
        chk("lit_len_code", 32'(o_err_code), 32'd2);
        fq = {8'h07, 8'h01, 8'h00};
        add_ck(1'b0);
        send_frame(fq, 0, 1'b1, -1);
        idle(2);
        chk("lit_type_code", 32'(o_err_code), 32'd1);
        fq = {8'h01, 8'h01};
        send_frame(fq, 0, 1'b1, -1);
        idle(2);
        chk("lit_early_code", 32'(o_err_code), 32'd2);
        chk("lit_en_keep", 32'(o_cap_enable), 32'd0);

        fq = {8'h05, 8'h00};
        add_ck(1'b0);
        send_frame(fq, 2, 1'b0, -1);
        fq = {8'h04, 8'h01, 8'h01};
        add_ck(1'b0);
        send_frame(fq, 2, 1'b1, -1);
        idle(3);
        chk("lit_trig", 32'(o_cap_trigger), 32'd1);

        i_def_chnnel = 8'd6;
        i_def_speed  = SPEED_W'(1000);
        i_def_start  = 1'b1;
        i_def_trig   = 1'b0;
        fq = {8'h03, 8'h01, 8'h00};
        add_ck(1'b0);
        send_frame(fq, 0, 1'b1, fq.size() - 2);
        idle(4);
        chk("lit_run_en", 32'(o_cap_enable), 32'd1);
        chk("lit_run_code", 32'(o_err_code), 32'd4);
        chk("lit_run_chan", 32'(o_cap_chnnel_num), 32'd6);
        chk("lit_run_speed", 32'(o_cap_speed), 32'd1000);
        i_system_run = 1'b0;
        idle(4);

        @(posedge i_clk); #1;
        bus.valid = 1'b1; bus.data = 8'h01; bus.last = 1'b0;
        @(posedge i_clk); #1;
        bus.data = 8'h01;
        @(posedge i_clk); #2;
        i_rst = 1'b1;
        model_clear();
        bus.valid = 1'b0;
        #1;
        chk("midrst_chan", 32'(o_cap_chnnel_num), 32'd0);
        chk("midrst_en", 32'(o_cap_enable), 32'd0);
        chk("midrst_code", 32'(o_err_code), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        idle(2);
        fq = {8'h04, 8'h01, 8'h00};
        add_ck(1'b0);
        send_frame(fq, 0, 1'b1, -1);
        lit_pulse(1'b1, 1'b0);
        chk("postrst_code", 32'(o_err_code), 32'd0);

`ifdef CAP_CMD_CHECKSUM_EN
        fq = {8'h04, 8'h01, 8'h01, 8'h06};
        send_frame(fq, 0, 1'b1, -1);
        idle(2);
        chk("lit_ck_trig", 32'(o_cap_trigger), 32'd1);
        fq = {8'h04, 8'h01, 8'h01, 8'h07};
        send_frame(fq, 0, 1'b1, -1);
        idle(2);
        chk("lit_ck_code", 32'(o_err_code), 32'd3);
`endif

        for (int k = 0; k < 300; k++) begin
            rand_frame();
            send_frame(fq, ($urandom_range(0, 3) == 0) ? 2 : 0,
                       $urandom_range(0, 4) == 0, -1);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
